uart_tx_framer: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_parity.sv | 23 ++
 rtl/uart_tx_framer.sv | 127 ++++++++++++
 tb/tb_uart_tx_framer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_parity.sv
// Parity bit generator over the transmitted data bits; pure combinational.
module uart_parity #(
    parameter int    DataWidth  = 8,
    parameter string ParityType = "even"
) (
    input  logic [DataWidth-1:0] data,
    output logic                 parity
);

    if (ParityType == "even") begin : g_even
        assign parity = ^data;
    end else if (ParityType == "odd") begin : g_odd
        assign parity = ~^data;
    end else if (ParityType == "mark") begin : g_mark
        assign parity = 1'b1;
    end else if (ParityType == "space") begin : g_space
        assign parity = 1'b0;
    end else begin : g_bad_type
        $error("uart_parity: unsupported ParityType %s", ParityType);
        assign parity = 1'b0;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit(s).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int    ClockFreq  = 50_000_000,
    parameter int    BaudRate   = 115_200,
    parameter int    DataWidth  = 8,
    parameter string ParityType = "none",
    parameter int    StopBits   = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int  ClksPerBit = clks_per_bit(ClockFreq, BaudRate);
    localparam bit  ParityEn   = (ParityType != "none");
    localparam int  CntW       = $clog2(ClksPerBit);
    localparam int  BitW       = $clog2(DataWidth + 1);

    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $error("uart_tx_framer: StopBits must be 1 or 2, got %0d", StopBits);
    end
    if (DataWidth < 5 || DataWidth > 9) begin : g_bad_width
        $error("uart_tx_framer: DataWidth must be 5..9, got %0d", DataWidth);
    end
    if (ClksPerBit < 2) begin : g_bad_baud
        $error("uart_tx_framer: ClockFreq/BaudRate must be >= 2");
    end

    uart_tx_state_t       state, next_state;
    logic [CntW-1:0]      clk_cnt;
    logic [BitW-1:0]      bit_idx;
    logic [DataWidth-1:0] shreg, shreg_d;
    logic                 par_gen, par_q;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 accept, bit_done;

    assign accept   = valid_i && ready_q;
    assign bit_done = (clk_cnt == CntW'(ClksPerBit - 1));

    if (ParityEn) begin : g_parity
        uart_parity #(
            .DataWidth (DataWidth),
            .ParityType(ParityType)
        ) u_parity (
            .data  (shreg),
            .parity(par_gen)
        );
    end else begin : g_no_parity
        assign par_gen = 1'b0;
    end

    // State register and datapath; reset pulls the line idle without waiting for a clock.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            shreg   <= shreg_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            if (state == START) begin
                par_q <= par_gen;
            end
            if (state != next_state) begin
                clk_cnt <= '0;
                bit_idx <= '0;
            end else if (state != IDLE) begin
                if (bit_done) begin
                    clk_cnt <= '0;
                    bit_idx <= bit_idx + 1'b1;
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = START;
            START:   if (bit_done) next_state = DATA;
            DATA:    if (bit_done && bit_idx == BitW'(DataWidth - 1))
                         next_state = ParityEn ? PARITY : STOP;
            PARITY:  if (bit_done) next_state = STOP;
            STOP:    if (bit_done && bit_idx == BitW'(StopBits - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so tx_o and ready_o come straight off flops.
    always_comb begin
        shreg_d = shreg;
        if (accept) begin
            shreg_d = data_i;
        end else if (state == DATA && bit_done) begin
            shreg_d = shreg >> 1;
        end
        ready_d = (next_state == IDLE);
        case (next_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_o    = tx_q;
    assign ready_o = ready_q;
    assign busy_o  = !ready_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench: seven framer configurations at 10 clocks per bit, checked by immediate assertions.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       valid [7];
    logic [7:0] data  [7];
    logic       tx    [7];
    logic       ready [7];
    logic       busy  [7];

    int   checks = 0;
    int   errors = 0;
    logic cap [0:299];
    int   frame_len;

    always #5 clk = ~clk;

    uart_tx_framer #(.ClockFreq(1_000_000), .BaudRate(100_000), .DataWidth(8),
                     .ParityType("none"), .StopBits(1))
    u_none (.clk_i(clk), .reset_i(reset_i), .data_i(data[0]), .valid_i(valid[0]),
            .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));

    uart_tx_framer #(.ClockFreq(1_000_000), .BaudRate(100_000), .DataWidth(8),
                     .ParityType("even"), .StopBits(1))
    u_even (.clk_i(clk), .reset_i(reset_i), .data_i(data[1]), .valid_i(valid[1]),
            .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));

    uart_tx_framer #(.ClockFreq(1_000_000), .BaudRate(100_000), .DataWidth(8),
                     .ParityType("odd"), .StopBits(1))
    u_odd (.clk_i(clk), .reset_i(reset_i), .data_i(data[2]), .valid_i(valid[2]),
           .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));

    uart_tx_framer #(.ClockFreq(1_000_000), .BaudRate(100_000), .DataWidth(8),
                     .ParityType("mark"), .StopBits(1))
    u_mark (.clk_i(clk), .reset_i(reset_i), .data_i(data[3]), .valid_i(valid[3]),
            .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]));

    uart_tx_framer #(.ClockFreq(1_000_000), .BaudRate(100_000), .DataWidth(8),
                     .ParityType("space"), .StopBits(1))
    u_space (.clk_i(clk), .reset_i(reset_i), .data_i(data[4]), .valid_i(valid[4]),
             .ready_o(ready[4]), .tx_o(tx[4]), .busy_o(busy[4]));

    uart_tx_framer #(.ClockFreq(1_000_000), .BaudRate(100_000), .DataWidth(8),
                     .ParityType("none"), .StopBits(2))
    u_stop2 (.clk_i(clk), .reset_i(reset_i), .data_i(data[5]), .valid_i(valid[5]),
             .ready_o(ready[5]), .tx_o(tx[5]), .busy_o(busy[5]));

    uart_tx_framer #(.ClockFreq(1_000_000), .BaudRate(100_000), .DataWidth(7),
                     .ParityType("even"), .StopBits(1))
    u_seven (.clk_i(clk), .reset_i(reset_i), .data_i(data[6][6:0]), .valid_i(valid[6]),
             .ready_o(ready[6]), .tx_o(tx[6]), .busy_o(busy[6]));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one payload for a single edge; returns on the first falling edge of the frame.
    task automatic send(input int idx, input logic [7:0] d);
        @(negedge clk);
        data[idx]  = d;
        valid[idx] = 1'b1;
        @(negedge clk);
        valid[idx] = 1'b0;
    endtask

    // Sample tx once per clock until ready returns, optionally pulsing valid mid-frame.
    task automatic capture(input int idx, input int pulse_at);
        frame_len = 0;
        for (int n = 0; n < 300; n++) begin
            if (ready[idx]) break;
            cap[n] = tx[idx];
            frame_len++;
            if (n == pulse_at) begin
                data[idx]  = 8'hFF;
                valid[idx] = 1'b1;
            end
            if (n == pulse_at + 1) valid[idx] = 1'b0;
            @(negedge clk);
        end
    endtask

    // bits[0] is the first bit on the line; each bit must hold for all ten clocks.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits);
        logic [9:0] obs;
        check($sformatf("%s len", tag), frame_len, nbits * 10);
        for (int k = 0; k < nbits; k++) begin
            for (int j = 0; j < 10; j++) obs[j] = cap[k * 10 + j];
            check($sformatf("%s bit%0d", tag, k), {22'd0, obs}, {22'd0, {10{bits[k]}}});
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lows;
        reset_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst tx", tx[0], 1'b1);
        check("rst ready", ready[0], 1'b1);
        check("rst busy", busy[0], 1'b0);
        reset_i = 1'b0;

        // Plain 8N1 frame.
        send(0, 8'hA5);
        check("none busy", busy[0], 1'b1);
        capture(0, 1000);
        check_frame("none A5", {1'b1, 8'hA5, 1'b0}, 10);

        // Parity variants on 0xA5 (four ones).
        send(1, 8'hA5); capture(1, 1000);
        check_frame("even A5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        send(2, 8'hA5); capture(2, 1000);
        check_frame("odd A5", {1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        send(3, 8'hA5); capture(3, 1000);
        check_frame("mark A5", {1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        send(4, 8'hA5); capture(4, 1000);
        check_frame("space A5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11);

        // Two stop bits: 90 clocks low, 20 high, 110 total.
        send(5, 8'h00); capture(5, 1000);
        check_frame("stop2 00", {2'b11, 8'h00, 1'b0}, 11);

        // Seven data bits with even parity.
        send(6, 8'h7F); capture(6, 1000);
        check_frame("seven 7F", {1'b1, 1'b1, 7'h7F, 1'b0}, 10);

        // Back-to-back with valid held high.
        @(negedge clk);
        data[0]  = 8'h55;
        valid[0] = 1'b1;
        @(negedge clk);
        data[0]  = 8'h0F;
        capture(0, 1000);
        check_frame("b2b 55", {1'b1, 8'h55, 1'b0}, 10);
        check("b2b gap tx", tx[0], 1'b1);
        @(negedge clk);
        check("b2b second start tx", tx[0], 1'b0);
        check("b2b second ready", ready[0], 1'b0);
        valid[0] = 1'b0;
        capture(0, 1000);
        check_frame("b2b 0F", {1'b1, 8'h0F, 1'b0}, 10);

        // Valid pulse while busy must not start another frame.
        send(0, 8'h00);
        capture(0, 25);
        check_frame("ignored 00", {1'b1, 8'h00, 1'b0}, 10);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!tx[0] || !ready[0]) lows++;
        end
        check("ignored stays idle", lows, 0);

        // Reset pulse while idle takes effect before any clock edge.
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("idle rst tx", tx[0], 1'b1);
        check("idle rst ready", ready[0], 1'b1);
        check("idle rst busy", busy[0], 1'b0);
        @(negedge clk);
        reset_i = 1'b0;

        // Reset during DATA aborts the frame immediately and it never resumes.
        send(0, 8'h00);
        repeat (30) @(negedge clk);
        check("pre-abort tx", tx[0], 1'b0);
        check("pre-abort busy", busy[0], 1'b1);
        reset_i = 1'b1;
        #1;
        check("abort tx", tx[0], 1'b1);
        check("abort ready", ready[0], 1'b1);
        check("abort busy", busy[0], 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (!tx[0] || !ready[0]) lows++;
        end
        check("abort no resume", lows, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
